ara_rst_seq: RTL and testbench
==============================

Name: ara_rst_seq

Overview:
Board-level reset sequencer that sits directly upstream of ara_soc and dm_top in the FPGA top level. It synchronises the PLL lock, debounces the board reset button, and requires the lock to be stable before releasing resets. It releases the fabric/L2/debug reset first, then the core reset after a delay. The core reset is additionally gated by the debug module's ndmreset. Lock-loss events are counted, and status is exposed for the board LEDs.

Parameters:
SyncStages, 2, number of flops in each input synchroniser (min 2)
DebounceCycles, 1_000_000, consecutive stable cycles before the debounced button changes (20 ms at 50 MHz)
LockStableCycles, 1024, cycles the lock and released button must both hold before fabric release (min 1)
CoreDelayCycles, 16, cycles between fabric release and core release (min 1)
HeartbeatDiv, 25_000_000, half-period of the heartbeat in cycles (feature only)

Ports:
clk_i  in  1  core clock (50 MHz PLL output)
rst_i  in  1  synchronous active-high reset
pll_locked_i  in  1  PLL lock, asynchronous
btn_rst_ni  in  1  board reset button, asynchronous, active-low (0 = pressed)
ndmreset_i  in  1  non-debug-module reset from dm_top, synchronous to clk_i
fabric_rst_no  out  1  active-low reset for SoC fabric, L2 and dm_top
core_rst_no  out  1  active-low reset for CVA6+Ara and UART
state_o  out  3  current FSM state encoding
lock_lost_cnt_o  out  8  saturating count of lock-loss events
heartbeat_o  out  1  blink output (see Optional Feature)

Behaviour:
- Reset: while rst_i=1 all flops clear on the clock edge.
  - State = S_RESET; fabric_rst_no=0, core_rst_no=0.
  - lock_lost_cnt_o=0, heartbeat_o=0.
  - Synchroniser chains = 0; debounced button btn_deb=0, i.e. treated as pressed.
- Synchronisation: pll_locked_i and btn_rst_ni each pass through SyncStages flops, producing lock_s and btn_s.
- Debounce:
  - btn_deb takes the value of btn_s only after btn_s has differed from btn_deb for DebounceCycles consecutive cycles.
  - Any bounce back to the current btn_deb value clears the counter.
  - lock_s is used unfiltered.
- FSM states and encodings:
  - S_RESET=0, S_WAIT_LOCK=1, S_STABLE=2, S_FABRIC=3, S_RUN=4.
  - A single counter cnt is cleared on every state change.
- Transitions:
  - S_RESET -> S_WAIT_LOCK unconditionally on the next cycle.
  - S_WAIT_LOCK -> S_STABLE when lock_s && btn_deb.
  - S_STABLE: if !lock_s || !btn_deb -> S_WAIT_LOCK. Else, when cnt==LockStableCycles-1 -> S_FABRIC. Else cnt++.
  - S_FABRIC: when cnt==CoreDelayCycles-1 -> S_RUN. Else cnt++.
  - S_FABRIC/S_RUN with !lock_s -> S_WAIT_LOCK; lock_lost_cnt_o increments, saturating at 255.
  - S_FABRIC/S_RUN with !btn_deb (and lock_s=1) -> S_WAIT_LOCK; no count increment.
  - Simultaneous lock loss and button press: lock loss has priority and is counted once.
- Outputs are registered and updated on the same edge as the state register.
  - fabric_rst_no = 1 exactly when the next state is S_FABRIC or S_RUN.
  - core_rst_no = 1 exactly when the next state is S_RUN and ndmreset_i=0 in the current cycle.
  - Consequence: ndmreset_i has 1-cycle latency to core_rst_no and never affects fabric_rst_no or the state.
- Latency: let t0 be the first cycle with lock_s=1 while btn_deb=1 in S_WAIT_LOCK.
  - fabric_rst_no rises at t0+LockStableCycles+1.
  - core_rst_no rises at t0+LockStableCycles+1+CoreDelayCycles, provided ndmreset_i=0.
- Re-entry to S_WAIT_LOCK: both outputs are 0 in the cycle the state becomes S_WAIT_LOCK (same edge). No glitch-free release is needed mid-sequence; the full sequence always restarts.
- rst_i asserted mid-operation: immediate return to the reset values on the next edge, including clearing lock_lost_cnt_o.

Optional Feature:
Macro: ARA_RST_SEQ_HEARTBEAT_EN.
- Defined: heartbeat_o toggles every HeartbeatDiv cycles while the state is S_RUN. Outside S_RUN it is forced to 0 and its divider is cleared.
- Undefined: heartbeat_o is tied to 0 and no divider logic exists. The port is always present.

Decomposition:
- Package ara_rst_pkg holds:
  - enum rst_state_e (3-bit, encodings above);
  - the default parameter constants;
  - function cnt_width(n) = $clog2(n+1).
- Sub-module ara_sync_filter: SyncStages synchroniser plus FilterCycles debounce, reset value parameterised.
  - Used for the button with FilterCycles=DebounceCycles.
  - Used for the lock with FilterCycles=1 (synchroniser only).

Test Plan:
Test values: SyncStages=2, DebounceCycles=8, LockStableCycles=16, CoreDelayCycles=4, HeartbeatDiv=3.
1. Power-up: rst_i pulse, button released, pll_locked_i rises at cycle 20 -> fabric_rst_no rises 16+1 cycles after lock_s is seen; core_rst_no rises 4 cycles later; state_o=4.
2. Lock glitch in S_STABLE: drop pll_locked_i for 1 cycle at cnt=10 -> return to S_WAIT_LOCK; full 16-cycle wait restarts; lock_lost_cnt_o stays 0.
3. Lock loss in S_RUN, repeated 300 times -> both resets 0 on the same edge; lock_lost_cnt_o saturates at 255.
4. Button bounce: 5-cycle press pulses -> no effect. 8-cycle stable press in S_RUN -> S_WAIT_LOCK, counter unchanged.
5. ndmreset_i=1 for 10 cycles in S_RUN -> core_rst_no=0 for exactly those 10 cycles shifted by one; fabric_rst_no stays 1; state_o stays 4.
6. ARA_RST_SEQ_HEARTBEAT_EN defined -> heartbeat_o period 6 cycles in S_RUN, 0 otherwise. Undefined -> constant 0.

Source files
------------

// File: rtl/ara_rst_pkg.sv
// Shared types and defaults for the board reset sequencer.
// The heartbeat feature is enabled by ARA_RST_SEQ_HEARTBEAT_EN in ara_rst_seq.
package ara_rst_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_FABRIC    = 3'd3,
        S_RUN       = 3'd4
    } rst_state_e;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned LOCK_STABLE_DEF     = 1024;
    localparam int unsigned CORE_DELAY_DEF      = 16;
    localparam int unsigned HEARTBEAT_DIV_DEF   = 25_000_000;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return unsigned'($clog2(n + 1));
    endfunction

endpackage

// File: rtl/ara_rst_seq_sync_filter.sv
// Multi-flop synchroniser followed by an optional consecutive-cycle debounce filter.
// FilterCycles <= 1 bypasses the filter and exposes the synchronised value directly.
module ara_sync_filter
    import ara_rst_pkg::*;
#(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = 1,
    parameter logic        RstVal       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SyncStages-1:0] chain;
    logic                  synced;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SyncStages{RstVal}};
        end else begin
            chain <= {chain[SyncStages-2:0], din};
        end
    end

    assign synced = chain[SyncStages-1];

    if (FilterCycles <= 1) begin : g_bypass
        assign dout = synced;
    end else begin : g_filter
        localparam int unsigned CntW = cnt_width(FilterCycles - 1);

        logic [CntW-1:0] cnt;
        logic            deb;

        // Output flips only on the FilterCycles-th consecutive differing cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                deb <= RstVal;
                cnt <= '0;
            end else if (synced == deb) begin
                cnt <= '0;
            end else if (cnt == CntW'(FilterCycles - 1)) begin
                deb <= synced;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign dout = deb;
    end

endmodule

// File: rtl/ara_rst_seq.sv
// Board reset sequencer: PLL-lock qualification, button debounce, staged fabric/core release.
// Define ARA_RST_SEQ_HEARTBEAT_EN to enable the S_RUN heartbeat divider.
module ara_rst_seq
    import ara_rst_pkg::*;
#(
    parameter int unsigned SyncStages       = SYNC_STAGES_DEF,
    parameter int unsigned DebounceCycles   = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LockStableCycles = LOCK_STABLE_DEF,
    parameter int unsigned CoreDelayCycles  = CORE_DELAY_DEF,
    parameter int unsigned HeartbeatDiv     = HEARTBEAT_DIV_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       btn_rst_ni,
    input  logic       ndmreset_i,
    output logic       fabric_rst_no,
    output logic       core_rst_no,
    output logic [2:0] state_o,
    output logic [7:0] lock_lost_cnt_o,
    output logic       heartbeat_o
);

    if (SyncStages < 2 || DebounceCycles < 1 || LockStableCycles < 1 ||
        CoreDelayCycles < 1 || HeartbeatDiv < 1) begin : g_bad_params
        $error("ara_rst_seq: parameter below its minimum");
    end

    localparam int unsigned CntMax = (LockStableCycles > CoreDelayCycles) ?
                                     LockStableCycles : CoreDelayCycles;
    localparam int unsigned CntW   = cnt_width(CntMax);

    logic            lock_s;
    logic            btn_deb;
    rst_state_e      state;
    rst_state_e      state_next;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_next;
    logic            lock_lost;
    logic            fabric_d;
    logic            core_d;
    logic [7:0]      lost_cnt;
    logic            fabric_q;
    logic            core_q;

    ara_sync_filter #(
        .SyncStages  (SyncStages),
        .FilterCycles(1),
        .RstVal      (1'b0)
    ) u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .din (pll_locked_i),
        .dout(lock_s)
    );

    ara_sync_filter #(
        .SyncStages  (SyncStages),
        .FilterCycles(DebounceCycles),
        .RstVal      (1'b0)
    ) u_btn_filter (
        .clk (clk_i),
        .rst (rst_i),
        .din (btn_rst_ni),
        .dout(btn_deb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_RESET;
            cnt      <= '0;
            fabric_q <= 1'b0;
            core_q   <= 1'b0;
            lost_cnt <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            fabric_q <= fabric_d;
            core_q   <= core_d;
            if (lock_lost && lost_cnt != '1) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

    // Lock loss is checked before the button so a simultaneous event is counted once.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lock_lost  = 1'b0;
        case (state)
            S_RESET: state_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s && btn_deb) state_next = S_STABLE;
            end
            S_STABLE: begin
                if (!lock_s || !btn_deb) begin
                    state_next = S_WAIT_LOCK;
                end else if (cnt == CntW'(LockStableCycles - 1)) begin
                    state_next = S_FABRIC;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_FABRIC: begin
                if (!lock_s) begin
                    state_next = S_WAIT_LOCK;
                    lock_lost  = 1'b1;
                end else if (!btn_deb) begin
                    state_next = S_WAIT_LOCK;
                end else if (cnt == CntW'(CoreDelayCycles - 1)) begin
                    state_next = S_RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_next = S_WAIT_LOCK;
                    lock_lost  = 1'b1;
                end else if (!btn_deb) begin
                    state_next = S_WAIT_LOCK;
                end
            end
            default: state_next = S_RESET;
        endcase
        if (state_next != state) cnt_next = '0;
    end

    always_comb begin
        fabric_d = (state_next == S_FABRIC) || (state_next == S_RUN);
        core_d   = (state_next == S_RUN) && !ndmreset_i;
    end

    assign fabric_rst_no   = fabric_q;
    assign core_rst_no     = core_q;
    assign state_o         = state;
    assign lock_lost_cnt_o = lost_cnt;

`ifdef ARA_RST_SEQ_HEARTBEAT_EN
    localparam int unsigned HbW = cnt_width(HeartbeatDiv);

    logic [HbW-1:0] hb_div;
    logic           hb;

    always_ff @(posedge clk_i) begin
        if (rst_i || state != S_RUN) begin
            hb_div <= '0;
            hb     <= 1'b0;
        end else if (hb_div == HbW'(HeartbeatDiv - 1)) begin
            hb_div <= '0;
            hb     <= ~hb;
        end else begin
            hb_div <= hb_div + 1'b1;
        end
    end

    assign heartbeat_o = hb;
`else
    assign heartbeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_ara_rst_seq.sv
// Scoreboard bench for ara_rst_seq: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ara_rst_seq;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 8;
    localparam int unsigned LOCK  = 16;
    localparam int unsigned CDLY  = 4;
    localparam int unsigned HBDIV = 3;

    localparam int SIG_ST = 0, SIG_FAB = 1, SIG_CORE = 2, SIG_LOST = 3, SIG_HB = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       pll_locked_i;
    logic       btn_rst_ni;
    logic       ndmreset_i;
    logic       fabric_rst_no;
    logic       core_rst_no;
    logic [2:0] state_o;
    logic [7:0] lock_lost_cnt_o;
    logic       heartbeat_o;

    ara_rst_seq #(
        .SyncStages      (SYNC),
        .DebounceCycles  (DEB),
        .LockStableCycles(LOCK),
        .CoreDelayCycles (CDLY),
        .HeartbeatDiv    (HBDIV)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .pll_locked_i   (pll_locked_i),
        .btn_rst_ni     (btn_rst_ni),
        .ndmreset_i     (ndmreset_i),
        .fabric_rst_no  (fabric_rst_no),
        .core_rst_no    (core_rst_no),
        .state_o        (state_o),
        .lock_lost_cnt_o(lock_lost_cnt_o),
        .heartbeat_o    (heartbeat_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    c;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int c, input int sig, input int val, input string name);
        exp_t e;
        e.c    = c;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic expect_outs(input int c, input int st, input int fab, input int core,
                               input string name);
        expect_at(c, SIG_ST,   st,   {name, "_state"});
        expect_at(c, SIG_FAB,  fab,  {name, "_fabric"});
        expect_at(c, SIG_CORE, core, {name, "_core"});
    endtask

    function automatic int actual(input int sig);
        case (sig)
            SIG_ST:   return int'(state_o);
            SIG_FAB:  return int'(fabric_rst_no);
            SIG_CORE: return int'(core_rst_no);
            SIG_LOST: return int'(lock_lost_cnt_o);
            default:  return int'(heartbeat_o);
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        int i;
        int act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].c == cyc) begin
                act = actual(q[i].sig);
                checks++;
                if (act != q[i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d expected %0d",
                             q[i].name, cyc, act, q[i].val);
                end
                q.delete(i);
            end else if (q[i].c < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d never sampled", q[i].name, q[i].c);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int hbx;
        int lost;
        rst_i        = 1'b1;
        pll_locked_i = 1'b0;
        btn_rst_ni   = 1'b1;
        ndmreset_i   = 1'b0;
        @(posedge clk);
        #1;

        // Reset values, then S_WAIT_LOCK one cycle after release.
        expect_outs(2, 0, 0, 0, "reset");
        expect_at(2, SIG_LOST, 0, "reset_lost");
        expect_at(2, SIG_HB,   0, "reset_hb");
        goto(3);
        rst_i = 1'b0;
        expect_outs(4, 1, 0, 0, "wait_lock");

        // Power-up: lock_s seen at k+2, fabric at +17, core 4 later.
        goto(23);
        k = cyc;
        pll_locked_i = 1'b1;
        expect_outs(k + 2,  1, 0, 0, "pu_t0");
        expect_outs(k + 3,  2, 0, 0, "pu_stable");
        expect_outs(k + 18, 2, 0, 0, "pu_pre_fabric");
        expect_outs(k + 19, 3, 1, 0, "pu_fabric");
        expect_outs(k + 22, 3, 1, 0, "pu_pre_core");
        expect_outs(k + 23, 4, 1, 1, "pu_run");
        expect_at(k + 22, SIG_HB, 0, "hb_fabric");
        for (int o = 0; o < 12; o++) begin
`ifdef ARA_RST_SEQ_HEARTBEAT_EN
            hbx = (o / 3) % 2;
`else
            hbx = 0;
`endif
            expect_at(k + 23 + o, SIG_HB, hbx, "hb_run");
        end
        goto(k + 36);

        // ndmreset for 10 cycles: core low for those cycles shifted by one.
        k = cyc;
        ndmreset_i = 1'b1;
        for (int o = 0; o < 12; o++) begin
            expect_at(k + o, SIG_CORE, (o >= 1 && o <= 10) ? 0 : 1, "ndm_core");
            expect_at(k + o, SIG_FAB, 1, "ndm_fabric");
            expect_at(k + o, SIG_ST,  4, "ndm_state");
        end
        goto(k + 10);
        ndmreset_i = 1'b0;
        goto(k + 14);

        // Short presses (5 and 7 cycles) must be filtered out.
        for (int p = 5; p <= 7; p += 2) begin
            k = cyc;
            btn_rst_ni = 1'b0;
            expect_outs(k + p + 10, 4, 1, 1, "bounce");
            goto(k + p);
            btn_rst_ni = 1'b1;
            goto(k + p + 12);
        end

        // Exactly 8-cycle press: S_WAIT_LOCK without counting; then resequence with lock glitch.
        k = cyc;
        btn_rst_ni = 1'b0;
        expect_outs(k + 10, 4, 1, 1, "press_pre");
        expect_outs(k + 11, 1, 0, 0, "press_exit");
        expect_at(k + 11, SIG_LOST, 0, "press_lost");
        goto(k + 8);
        btn_rst_ni = 1'b1;
        expect_outs(k + 18, 1, 0, 0, "release_wait");
        expect_outs(k + 19, 2, 0, 0, "release_stable");
        goto(k + 27);
        pll_locked_i = 1'b0;
        goto(k + 28);
        pll_locked_i = 1'b1;
        expect_outs(k + 29, 2, 0, 0, "glitch_cnt10");
        expect_outs(k + 30, 1, 0, 0, "glitch_wait");
        expect_outs(k + 31, 2, 0, 0, "glitch_restart");
        expect_outs(k + 46, 2, 0, 0, "glitch_pre_fabric");
        expect_outs(k + 47, 3, 1, 0, "glitch_fabric");
        expect_at(k + 47, SIG_LOST, 0, "glitch_lost");
        expect_outs(k + 50, 3, 1, 0, "glitch_pre_core");
        expect_outs(k + 51, 4, 1, 1, "glitch_run");
        goto(k + 55);

        // 300 lock losses in S_RUN; counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            k = cyc;
            lost = (i + 1 > 255) ? 255 : i + 1;
            pll_locked_i = 1'b0;
            expect_outs(k + 2, 4, 1, 1, "loss_pre");
            expect_outs(k + 3, 1, 0, 0, "loss_exit");
            expect_at(k + 3, SIG_LOST, lost, "loss_cnt");
            expect_outs(k + 24, 4, 1, 1, "loss_rerun");
            goto(k + 1);
            pll_locked_i = 1'b1;
            goto(k + 26);
        end

        // rst_i mid-operation returns everything to reset values.
        k = cyc;
        expect_at(k, SIG_LOST, 255, "sat_lost");
        rst_i = 1'b1;
        expect_outs(k + 1, 0, 0, 0, "midrst");
        expect_at(k + 1, SIG_LOST, 0, "midrst_lost");
        expect_at(k + 1, SIG_HB,   0, "midrst_hb");
        goto(k + 2);
        rst_i = 1'b0;
        expect_outs(k + 3, 1, 0, 0, "midrst_wait");
        goto(k + 6);

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL leftover: %0d expectations unsampled, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
